ddr3_req_arbiter: RTL

Sequencer and arbiter that shares the single DDR3 application-interface engine between four DMA requesters. Each requester posts a read or write job with a dword address and a dword length. The arbiter grants one job at a time, drives the engine's ingress or egress enable and address, and counts transferred dwords from the engine strobes. It then releases the engine, waits for it to return idle, and reports completion. It sits between the PPFIFO/DMA channel logic and the DDR3 app-interface engine.

---
 rtl/ddr3_req_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ddr3_req_arbiter.sv
// ddr3_req_arbiter
//   Shares the single DDR3 app-interface engine between four DMA requesters.
//   Each requester posts a read or write job (dword address, dword length). One job is
//   granted at a time; the arbiter drives the engine enable and address, counts the
//   engine strobes, waits for the engine to go idle and pulses o_done to the owner.
//
// Build option:
//   DDR3_ARB_WR_PRIORITY_EN  when defined, any pending write wins over all reads
//                            (round-robin within each class); otherwise pure round-robin.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_init_calib_complete    no grant is issued while low
//   i_req/i_req_wr           per-requester job request (level) and direction (1 = write)
//   i_req_addr/i_req_len     per-requester start dword address / length in dwords
//   o_gnt/o_done             one-hot grant and one-cycle completion pulse
//   o_busy                   arbiter not idle
//   o_ingress_en/o_egress_en engine write / read enable
//   o_dword_addr             latched start address for the engine
//   i_ingress_stb/i_egress_stb  engine consumed / returned one dword
//   i_idle                   engine idle
module ddr3_req_arbiter #(
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int NUM_REQ        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_init_calib_complete,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ-1:0]                     i_req_wr,
  input  logic [NUM_REQ*(MEM_ADDR_DEPTH-2)-1:0]  i_req_addr,
  input  logic [NUM_REQ*24-1:0]                  i_req_len,
  output logic [NUM_REQ-1:0]                     o_gnt,
  output logic [NUM_REQ-1:0]                     o_done,
  output logic                                   o_busy,
  output logic                                   o_ingress_en,
  output logic                                   o_egress_en,
  output logic [MEM_ADDR_DEPTH-3:0]              o_dword_addr,
  input  logic                                   i_ingress_stb,
  input  logic                                   i_egress_stb,
  input  logic                                   i_idle
);

  localparam int AW = MEM_ADDR_DEPTH - 2;

  typedef enum logic [2:0] {IDLE, ARB, XFER, DRAIN, DONE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_ptr;
  logic [1:0]   r_idx;
  logic         r_wr;
  logic [23:0]  r_len;
  logic [23:0]  r_cnt;
  logic         r_drain_first;

  logic [NUM_REQ-1:0] w_cand;
  logic [1:0]         w_idx;
  logic [1:0]         w_win;
  logic               w_win_vld;
  int unsigned        w_sel;
  logic [AW-1:0]      w_addr_sel;
  logic [23:0]        w_len_sel;
  logic               w_wr_sel;
  logic               w_stb;
  logic [23:0]        w_cnt_inc;

  // Winner selection: first candidate at or after the pointer, scanning upward with wrap.
  always_comb begin
`ifdef DDR3_ARB_WR_PRIORITY_EN
    w_cand = ((i_req & i_req_wr) != '0) ? (i_req & i_req_wr) : i_req;
`else
    w_cand = i_req;
`endif
    w_win     = r_ptr;
    w_win_vld = 1'b0;
    w_idx     = r_ptr;
    // Scan from the far end down so the nearest candidate is the last one written.
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_cand[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
    w_sel      = 32'(w_win);
    w_addr_sel = i_req_addr[w_sel*AW +: AW];
    w_len_sel  = i_req_len[w_sel*24 +: 24];
    w_wr_sel   = i_req_wr[w_win];
  end

  // Only strobes of the granted direction advance the count.
  assign w_stb     = r_wr ? i_ingress_stb : i_egress_stb;
  assign w_cnt_inc = r_cnt + 24'd1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_init_calib_complete && (i_req != '0)) w_state_nxt = ARB;
      end
      ARB: begin
        if (!w_win_vld) begin
          w_state_nxt = IDLE;
        end else if (w_len_sel == 24'd0) begin
          // Zero-length job: no enable, but still confirm the engine is idle before DONE.
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_stb && (w_cnt_inc == r_len)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_drain_first && i_idle) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= 2'd0;
      r_idx         <= 2'd0;
      r_wr          <= 1'b0;
      r_len         <= 24'd0;
      r_cnt         <= 24'd0;
      r_drain_first <= 1'b0;
      o_gnt         <= '0;
      o_done        <= '0;
      o_busy        <= 1'b0;
      o_ingress_en  <= 1'b0;
      o_egress_en   <= 1'b0;
      o_dword_addr  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      o_busy        <= (w_state_nxt != IDLE);
      o_done        <= '0;
      r_drain_first <= 1'b0;
      unique case (r_state)
        ARB: begin
          if (w_win_vld) begin
            r_idx         <= w_win;
            r_wr          <= w_wr_sel;
            r_len         <= w_len_sel;
            r_cnt         <= 24'd0;
            o_dword_addr  <= w_addr_sel;
            o_gnt         <= NUM_REQ'(1) << w_win;
            o_ingress_en  <= (w_len_sel != 24'd0) && w_wr_sel;
            o_egress_en   <= (w_len_sel != 24'd0) && !w_wr_sel;
            r_drain_first <= (w_len_sel == 24'd0);
          end
        end
        XFER: begin
          if (w_stb) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              o_ingress_en  <= 1'b0;
              o_egress_en   <= 1'b0;
              r_drain_first <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_state_nxt == DONE) o_done <= o_gnt;
        end
        DONE: begin
          o_gnt <= '0;
          r_ptr <= r_idx + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
